// File: rtl/bumpy_game_pkg.sv
// rtl/bumpy_game_pkg.sv - shared types and widths for the bumpy game-state logic
package bumpy_game_pkg;

    localparam int LIVES_W     = 3;
    localparam int FRAME_CNT_W = 8;

    typedef enum logic [1:0] {
        PLAYING   = 2'd0,
        INVULN    = 2'd1,
        GAME_OVER = 2'd2
    } hit_state_t;

endpackage

// File: rtl/frame_contact_latch.sv
// rtl/frame_contact_latch.sv - accumulates two contact inputs over a frame and latches them at frame start
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start_of_frame    one-clock pulse closing the current frame
//   coll_a, coll_b    per-pixel contact inputs (b is a sub-class of contact)
//   contact_any       any a/b contact seen in the previous frame
//   contact_b         b contact seen in the previous frame
module frame_contact_latch (
    input  logic clk,
    input  logic reset,
    input  logic start_of_frame,
    input  logic coll_a,
    input  logic coll_b,
    output logic contact_any,
    output logic contact_b
);

    logic acc_a;
    logic acc_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_a       <= 1'b0;
            acc_b       <= 1'b0;
            contact_any <= 1'b0;
            contact_b   <= 1'b0;
        end else if (start_of_frame) begin
            // Contact in the frame-start cycle still belongs to the frame being closed.
            contact_any <= acc_a | acc_b | coll_a | coll_b;
            contact_b   <= acc_b | coll_b;
            acc_a       <= 1'b0;
            acc_b       <= 1'b0;
        end else begin
            acc_a <= acc_a | coll_a;
            acc_b <= acc_b | coll_b;
        end
    end

endmodule

// File: rtl/bumpy_hit_manager.sv
// rtl/bumpy_hit_manager.sv - lives, invulnerability/blink and game-over state driven by frame hit pulses
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   startOfFrame                    one-clock frame-start pulse
//   SingleHitPulse                  one-clock hit pulse (at most one per frame)
//   collision_bumpy_platform        bumpy/platform overlap
//   collision_bumpy_transplatform   bumpy/transparent-platform overlap
//   restart                         one-clock restart request
//   lives                           remaining lives
//   invulnerable                    high while invulnerable after a hit
//   bumpy_visible                   sprite draw enable, blinks while invulnerable
//   game_over                       high once all lives are gone
//   hit_taken                       one-clock pulse per accepted hit
//   on_platform, on_transplatform   contact seen during the previous frame
module bumpy_hit_manager
    import bumpy_game_pkg::*;
#(
    parameter int INIT_LIVES    = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int BLINK_FRAMES  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               SingleHitPulse,
    input  logic               collision_bumpy_platform,
    input  logic               collision_bumpy_transplatform,
    input  logic               restart,
    output logic [LIVES_W-1:0] lives,
    output logic               invulnerable,
    output logic               bumpy_visible,
    output logic               game_over,
    output logic               hit_taken,
    output logic               on_platform,
    output logic               on_transplatform
);

    localparam logic [LIVES_W-1:0]     INIT_L  = LIVES_W'(INIT_LIVES);
    localparam logic [FRAME_CNT_W-1:0] INV_LD  = FRAME_CNT_W'(INVULN_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] BLK_LD  = FRAME_CNT_W'(BLINK_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] CNT_ONE = FRAME_CNT_W'(1);

    hit_state_t             state;
    logic [FRAME_CNT_W-1:0] inv_cnt;
    logic [FRAME_CNT_W-1:0] blink_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= PLAYING;
            lives         <= INIT_L;
            inv_cnt       <= '0;
            blink_cnt     <= '0;
            invulnerable  <= 1'b0;
            bumpy_visible <= 1'b1;
            game_over     <= 1'b0;
            hit_taken     <= 1'b0;
        end else begin
            hit_taken <= 1'b0;
            if (restart) begin
                // Restart wins over any hit arriving in the same cycle.
                state         <= PLAYING;
                lives         <= INIT_L;
                inv_cnt       <= '0;
                blink_cnt     <= '0;
                invulnerable  <= 1'b0;
                bumpy_visible <= 1'b1;
                game_over     <= 1'b0;
            end else begin
                case (state)
                    PLAYING: begin
                        if (SingleHitPulse && lives != '0) begin
                            hit_taken <= 1'b1;
                            if (lives == LIVES_W'(1)) begin
                                lives         <= '0;
                                state         <= GAME_OVER;
                                game_over     <= 1'b1;
                                bumpy_visible <= 1'b1;
                            end else begin
                                // Fresh counters are not decremented even if this is a frame-start cycle.
                                lives         <= lives - LIVES_W'(1);
                                state         <= INVULN;
                                invulnerable  <= 1'b1;
                                inv_cnt       <= INV_LD;
                                blink_cnt     <= BLK_LD;
                                bumpy_visible <= 1'b0;
                            end
                        end
                    end
                    INVULN: begin
                        if (startOfFrame) begin
                            if (inv_cnt == CNT_ONE) begin
                                state         <= PLAYING;
                                invulnerable  <= 1'b0;
                                bumpy_visible <= 1'b1;
                                inv_cnt       <= '0;
                                blink_cnt     <= '0;
                            end else begin
                                inv_cnt <= inv_cnt - CNT_ONE;
                                if (blink_cnt == CNT_ONE) begin
                                    blink_cnt     <= BLK_LD;
                                    bumpy_visible <= ~bumpy_visible;
                                end else begin
                                    blink_cnt <= blink_cnt - CNT_ONE;
                                end
                            end
                        end
                    end
                    GAME_OVER: begin
                        lives         <= '0;
                        game_over     <= 1'b1;
                        bumpy_visible <= 1'b1;
                        invulnerable  <= 1'b0;
                    end
                    default: begin
                        state <= PLAYING;
                    end
                endcase
            end
        end
    end

    frame_contact_latch u_contact (
        .clk            (clk),
        .reset          (reset),
        .start_of_frame (startOfFrame),
        .coll_a         (collision_bumpy_platform),
        .coll_b         (collision_bumpy_transplatform),
        .contact_any    (on_platform),
        .contact_b      (on_transplatform)
    );

endmodule

// File: tb/tb_bumpy_hit_manager.sv
// tb/tb_bumpy_hit_manager.sv - randomized self-checking bench for bumpy_hit_manager
module tb_bumpy_hit_manager;

    logic clk = 1'b0;
    logic reset;
    logic sof, hit, cp, ct, rs;

    logic [2:0] lives_a, lives_b;
    logic inv_a, vis_a, go_a, ht_a, onp_a, ont_a;
    logic inv_b, vis_b, go_b, ht_b, onp_b, ont_b;

    always #5 clk = ~clk;

    bumpy_hit_manager #(.INIT_LIVES(3), .INVULN_FRAMES(60), .BLINK_FRAMES(4)) dut_a (
        .clk(clk), .reset(reset), .startOfFrame(sof), .SingleHitPulse(hit),
        .collision_bumpy_platform(cp), .collision_bumpy_transplatform(ct), .restart(rs),
        .lives(lives_a), .invulnerable(inv_a), .bumpy_visible(vis_a), .game_over(go_a),
        .hit_taken(ht_a), .on_platform(onp_a), .on_transplatform(ont_a)
    );

    bumpy_hit_manager #(.INIT_LIVES(2), .INVULN_FRAMES(1), .BLINK_FRAMES(2)) dut_b (
        .clk(clk), .reset(reset), .startOfFrame(sof), .SingleHitPulse(hit),
        .collision_bumpy_platform(cp), .collision_bumpy_transplatform(ct), .restart(rs),
        .lives(lives_b), .invulnerable(inv_b), .bumpy_visible(vis_b), .game_over(go_b),
        .hit_taken(ht_b), .on_platform(onp_b), .on_transplatform(ont_b)
    );

    // Reference model: mode 0 playing, 1 invulnerable, 2 game over;
    // elapsed counts frame starts since the accepted hit.
    typedef struct {
        int lives; int mode; int elapsed;
        bit hit; bit ap; bit at; bit onp; bit ont;
        int init; int invf; int blk;
    } mdl_t;

    mdl_t ma, mb;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset(input mdl_t m);
        mdl_t n = m;
        n.lives = m.init; n.mode = 0; n.elapsed = 0;
        n.hit = 0; n.ap = 0; n.at = 0; n.onp = 0; n.ont = 0;
        return n;
    endfunction

    function automatic mdl_t step(input mdl_t m, input bit f, input bit h,
                                  input bit p, input bit t, input bit r);
        mdl_t n = m;
        n.hit = 0;
        if (f) begin
            n.onp = m.ap | m.at | p | t;
            n.ont = m.at | t;
            n.ap = 0; n.at = 0;
        end else begin
            n.ap = m.ap | p;
            n.at = m.at | t;
        end
        if (r) begin
            n.lives = m.init; n.mode = 0; n.elapsed = 0;
        end else if (m.mode == 0) begin
            if (h && m.lives >= 1) begin
                n.hit = 1;
                n.lives = m.lives - 1;
                n.mode = (m.lives == 1) ? 2 : 1;
                n.elapsed = 0;
            end
        end else if (m.mode == 1) begin
            if (f) begin
                if (m.elapsed + 1 == m.invf) n.mode = 0;
                else n.elapsed = m.elapsed + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [8:0] expv(input mdl_t m);
        logic vis;
        vis = (m.mode != 1) ? 1'b1 : 1'(((m.elapsed / m.blk) % 2) == 1);
        return {3'(m.lives), m.mode == 1, vis, m.mode == 2, m.hit, m.onp, m.ont};
    endfunction

    function automatic logic [8:0] gota();
        return {lives_a, inv_a, vis_a, go_a, ht_a, onp_a, ont_a};
    endfunction

    function automatic logic [8:0] gotb();
        return {lives_b, inv_b, vis_b, go_b, ht_b, onp_b, ont_b};
    endfunction

    task automatic tick(input bit f, input bit h, input bit p, input bit t, input bit r,
                        input string tag);
        sof = f; hit = h; cp = p; ct = t; rs = r;
        @(posedge clk);
        ma = step(ma, f, h, p, t, r);
        mb = step(mb, f, h, p, t, r);
        #1;
        check({tag, "_A"}, 32'(gota()), 32'(expv(ma)));
        check({tag, "_B"}, 32'(gotb()), 32'(expv(mb)));
    endtask

    task automatic frame(input int len, input int hit_at, input int p_lo, input int p_hi,
                         input bit t_sof, input int rs_at, input string tag);
        for (int c = 0; c < len; c++)
            tick(c == 0, c == hit_at, (c >= p_lo) && (c < p_hi), t_sof && (c == 0),
                 c == rs_at, tag);
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        ma = mdl_reset(ma);
        mb = mdl_reset(mb);
        check({tag, "_A"}, 32'(gota()), 32'(expv(ma)));
        check({tag, "_B"}, 32'(gotb()), 32'(expv(mb)));
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        ma.init = 3; ma.invf = 60; ma.blk = 4;
        mb.init = 2; mb.invf = 1;  mb.blk = 2;
        ma = mdl_reset(ma);
        mb = mdl_reset(mb);
        reset = 1'b1; sof = 0; hit = 0; cp = 0; ct = 0; rs = 0;
        #3;
        check("reset_A", 32'(gota()), 32'(expv(ma)));
        check("reset_B", 32'(gotb()), 32'(expv(mb)));
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) frame(6, -1, 0, 0, 1'b0, -1, "idle");

        // A hit every frame, alternating between the frame-start cycle and mid-frame.
        for (int i = 0; i < 135; i++) frame(4, (i % 2) ? 2 : 0, 0, 0, 1'b0, -1, "hit_every");

        frame(5, 2, 0, 0, 1'b0, 2, "restart_hit");
        frame(5, -1, 0, 0, 1'b0, -1, "post_restart");

        frame(10, -1, 2, 7, 1'b0, -1, "plat5");
        frame(10, -1, 0, 0, 1'b0, -1, "plat_next");
        frame(10, -1, 0, 0, 1'b0, -1, "plat_clear");
        frame(6, -1, 0, 0, 1'b1, -1, "trans_sof");
        frame(6, -1, 0, 0, 1'b0, -1, "trans_next");
        frame(6, -1, 0, 0, 1'b0, -1, "trans_clear");

        for (int i = 0; i < 400; i++) begin
            int len, hat;
            len = $urandom_range(3, 8);
            hat = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len - 1)) : -1;
            for (int c = 0; c < len; c++)
                tick(c == 0, c == hat, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 299) == 0, "rand");
        end

        frame(5, -1, 0, 0, 1'b0, 1, "pre_rst");
        frame(5, 1, 0, 0, 1'b0, -1, "inv_hit");
        for (int i = 0; i < 5; i++) frame(5, -1, 1, 3, 1'b0, -1, "inv_mid");
        async_reset("async_rst");
        for (int i = 0; i < 3; i++) frame(5, -1, 0, 0, 1'b0, -1, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
